pulse_fsm: RTL and testbench

PULSE_FSM -- requirements
Module: pulse_fsm

---
 rtl/pulse_fsm.sv | 71 +++++++
 tb/tb_pulse_fsm.sv | 109 ++++++++++
 2 files changed

// File: rtl/pulse_fsm.sv
// Moore edge/level detector on s: one-cycle pulse P at the start of each high period, level L during it.
// Optional PULSE_FSM_SYNC_EN inserts a two-flop synchronizer on s ahead of the state machine.
module pulse_fsm (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic P,
  output logic L,
  output logic A,
  output logic B
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EDGE = 2'b01,
    HOLD = 2'b10,
    FALL = 2'b11
  } state_t;

  state_t state;
  logic   s_in;

`ifdef PULSE_FSM_SYNC_EN
  logic s_p0;
  logic s_p1;

  // synchronizer stages: s -> s_p0 -> s_p1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_p0 <= 1'b0;
      s_p1 <= 1'b0;
    end else begin
      s_p0 <= s;
      s_p1 <= s_p0;
    end
  end

  assign s_in = s_p1;
`else
  assign s_in = s;
`endif

  function automatic state_t next_state(input state_t cur, input logic trig);
    state_t nxt;
    case (cur)
      IDLE:    nxt = trig ? EDGE : IDLE;
      EDGE:    nxt = trig ? HOLD : FALL;
      HOLD:    nxt = trig ? HOLD : FALL;
      FALL:    nxt = trig ? EDGE : IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  // P and L are registered from the next state so they always match the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      P     <= 1'b0;
      L     <= 1'b0;
    end else begin
      state <= next_state(state, s_in);
      P     <= (next_state(state, s_in) == EDGE);
      L     <= (next_state(state, s_in) == EDGE) || (next_state(state, s_in) == HOLD);
    end
  end

  assign A = state[1];
  assign B = state[0];

endmodule

// File: tb/tb_pulse_fsm.sv
// Directed bench for pulse_fsm (default build, no synchronizer): state sequence, pulse/level decode, async reset.
module tb_pulse_fsm;

  logic clk;
  logic rst;
  logic s;
  logic P;
  logic L;
  logic A;
  logic B;

  int total;
  int bad;

  pulse_fsm dut (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .P   (P),
    .L   (L),
    .A   (A),
    .B   (B)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [1:0] st, input logic p, input logic l);
    total++;
    assert ({A, B} === st) else begin
      bad++;
      $error("FAIL %s state observed=%b expected=%b", tag, {A, B}, st);
    end
    total++;
    assert (P === p) else begin
      bad++;
      $error("FAIL %s P observed=%b expected=%b", tag, P, p);
    end
    total++;
    assert (L === l) else begin
      bad++;
      $error("FAIL %s L observed=%b expected=%b", tag, L, l);
    end
  endtask

  // drive s, take one rising edge, sample 1 time unit later
  task automatic step(input logic sv, input string tag, input logic [1:0] st,
                      input logic p, input logic l);
    s = sv;
    @(posedge clk);
    #1;
    check(tag, st, p, l);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    s     = 1'b0;

    // reset held while clock runs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 2'b00, 1'b0, 1'b0);
    end

    rst = 1'b1;
    step(1'b0, "idle_0", 2'b00, 1'b0, 1'b0);
    step(1'b0, "idle_1", 2'b00, 1'b0, 1'b0);

    // long high period: one pulse only
    step(1'b1, "long_e1", 2'b01, 1'b1, 1'b1);
    step(1'b1, "long_e2", 2'b10, 1'b0, 1'b1);
    step(1'b1, "long_e3", 2'b10, 1'b0, 1'b1);
    step(1'b1, "long_e4", 2'b10, 1'b0, 1'b1);

    // fall out of HOLD
    step(1'b0, "fall_e1", 2'b11, 1'b0, 1'b0);
    step(1'b0, "fall_e2", 2'b00, 1'b0, 1'b0);

    // single-cycle high
    step(1'b1, "short_e1", 2'b01, 1'b1, 1'b1);
    step(1'b0, "short_e2", 2'b11, 1'b0, 1'b0);
    step(1'b0, "short_e3", 2'b00, 1'b0, 1'b0);

    // one-cycle low gap during HOLD re-triggers
    step(1'b1, "gap_e1", 2'b01, 1'b1, 1'b1);
    step(1'b1, "gap_e2", 2'b10, 1'b0, 1'b1);
    step(1'b0, "gap_low", 2'b11, 1'b0, 1'b0);
    step(1'b1, "gap_retrig", 2'b01, 1'b1, 1'b1);
    step(1'b1, "gap_hold", 2'b10, 1'b0, 1'b1);

    // async reset between edges while in HOLD
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, "post_rst", 2'b01, 1'b1, 1'b1);
    step(1'b1, "post_rst_hold", 2'b10, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
